matvec_ctrl: RTL and testbench
==============================

# matvec_ctrl

Sequencer for a bank of `ROWS` MAC units computing `C = A·B`, where A is `ROWS`×`COLS` and B is a `COLS` vector. Each A row is streamed from its own FIFO and B from one broadcast FIFO. The block issues lock-step FIFO reads, drives the shared MAC clear and per-row enables, tolerates FIFO underflow by stalling, and captures all `ROWS` accumulator results into an output register bank. It sits between the FIFO fill logic and the MAC array, under a top-level start/done handshake.

## Interface
- `DATA_WIDTH`, 8: operand width; accumulator width is `3*DATA_WIDTH`.
- `ROWS`, 8: number of MAC units / A FIFOs.
- `COLS`, 8: vector length (MAC ops per result), ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin one computation; sampled in IDLE only.
- `abort` in 1: synchronous cancel, any state.
- `a_empty` in `ROWS`: per-row A FIFO empty flags.
- `b_empty` in 1: B FIFO empty flag.
- `fifo_rd_en` out `ROWS+1`: bits [ROWS-1:0] read the A FIFOs; bit [ROWS] reads the B FIFO.
- `mac_clr` out 1: clear for all MACs.
- `mac_en` out `ROWS`: per-MAC accumulate enable; all bits are always equal.
- `mac_c` in `ROWS*3*DATA_WIDTH`: MAC accumulator outputs; row r at `[r*3*DATA_WIDTH +: 3*DATA_WIDTH]`.
- `res` out `ROWS*3*DATA_WIDTH`: captured results, same packing as `mac_c`.
- `res_valid` out 1: `res` holds a completed computation.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: single-cycle completion pulse.

## Operation
- **FSM states:** IDLE, CLEAR, RUN, DRAIN, CAPTURE.
- **IDLE, `start`=1:** go to CLEAR and clear `res_valid`.
- **CLEAR:** assert `mac_clr` for one cycle; reset the column counter to 0; go to RUN.
- **RUN, read fire:** a read fires when no bit of `a_empty` is set and `b_empty`=0.
  - On fire: assert all `fifo_rd_en` bits in the same cycle and increment the counter.
  - Otherwise: assert no read bits (stall).
  - Reads are never partial across rows.
- **RUN, exit:** when the counter reaches `COLS` on a fire, go to DRAIN.
- **Enable timing:** FIFOs have registered output with 1-cycle read latency, so `mac_en` is a 1-cycle-delayed copy of the fire signal, replicated to all rows.
- **DRAIN:** one cycle; the last `mac_en` is asserted here.
- **CAPTURE:** latch `mac_c` into `res`; set `res_valid`; go to IDLE; `done` pulses on the next cycle.
- **`abort`:** return to IDLE at once.
  - Clear `mac_en`, drop all reads, leave `res`/`res_valid` unchanged (already cleared if the run had started), no `done`.
  - An enable already pipelined from the abort cycle is cancelled.
  - `abort` has priority over `start`.
- **`start` while busy:** ignored; not queued.
- **Counter:** width `$clog2(COLS+1)`; it never wraps within a run.
- **Arithmetic:** the block does no arithmetic on data.
- **Reset values:** all outputs 0, `res` 0, state IDLE.
- **Reset mid-run:** same as reset values; FIFO contents are not the block's concern.

## Timing
- **No-stall run, `start` sampled at cycle 0:**
  - CLEAR cycle 1 (`mac_clr`=1).
  - Fires cycles 2..COLS+1.
  - `mac_en` cycles 3..COLS+2.
  - CAPTURE cycle COLS+3.
  - `done` and `res_valid` high at cycle COLS+4.
  - COLS=8: `done` at cycle 12.
- **Stalls:** each stalled RUN cycle adds exactly one cycle to completion; `mac_en` is low in the cycle after a stall.
- **Outputs:** `mac_clr` and `mac_en` are never high in the same cycle. `busy` falls in the cycle `done` pulses.
- **Back-to-back:** `start` held high re-enters CLEAR on the cycle `done` pulses (IDLE sees `start`).

## Structure
- `matvec_pkg`: FSM state enum `mv_state_t`; default `DATA_WIDTH`/`ROWS`/`COLS` constants; `ACC_W = 3*DATA_WIDTH`.
- Single module, no sub-module. The FSM, counter, enable delay register and capture register bank are small enough to live together.

## Test plan
- **Basic run:** ROWS=COLS=8, A[r][c]=r+1, B[c]=c+1, no stalls → `done` at cycle 12 after `start`; `res` row r = 36*(r+1); `res_valid`=1.
- **Single-source stall:** `b_empty` held high for cycles 4–6 of RUN → no `fifo_rd_en` bits in those cycles; `done` at cycle 15; identical results.
- **Partial A stall:** `a_empty[5]` pulsed high for one cycle mid-run → all reads stall together; no row gets an extra or missing `mac_en`; results correct.
- **Abort mid-run:** `abort` at fire 4 → IDLE next cycle; `mac_en` low thereafter; no `done`; `res_valid` stays 0; a fresh `start` then yields correct results.
- **Start while busy:** `start` pulsed during RUN → ignored, exactly one `done`. Max-value check: A=B=255, COLS=8 → each result = 520200, fits `ACC_W`=24.
- **Reset mid-RUN:** assert `rst_n`=0 during RUN → all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared types and default sizing for the matrix-vector MAC sequencer.
package matvec_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ROWS_DEF       = 8;
    localparam int COLS_DEF       = 8;
    localparam int ACC_W          = 3 * DATA_WIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        CAPTURE
    } mv_state_t;

    function automatic int acc_width(input int data_width);
        return 3 * data_width;
    endfunction
endpackage

// File: rtl/matvec_ctrl.sv
// Sequences lock-step A-row/B FIFO reads into a MAC bank and captures the results.
// Reads stall as a group whenever any source FIFO is empty.
module matvec_ctrl
    import matvec_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int COLS       = COLS_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [ROWS-1:0]                        a_empty,
    input  logic                                   b_empty,
    output logic [ROWS:0]                          fifo_rd_en,
    output logic                                   mac_clr,
    output logic [ROWS-1:0]                        mac_en,
    input  logic [ROWS*acc_width(DATA_WIDTH)-1:0]  mac_c,
    output logic [ROWS*acc_width(DATA_WIDTH)-1:0]  res,
    output logic                                   res_valid,
    output logic                                   busy,
    output logic                                   done
);
    localparam int CW = $clog2(COLS + 1);

    mv_state_t     state;
    logic [CW-1:0] cnt;
    logic          en_q;
    logic          fire;

    // Read strobes must coincide with the empty flags, so fire stays combinational.
    assign fire       = (state == RUN) && !abort && !(|a_empty) && !b_empty;
    assign fifo_rd_en = {(ROWS + 1){fire}};
    // FIFO data appears one cycle after the read, hence the delayed enable.
    assign mac_en     = {ROWS{en_q}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            en_q      <= 1'b0;
            mac_clr   <= 1'b0;
            res       <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            en_q    <= fire;
            mac_clr <= 1'b0;
            done    <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                en_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= CLEAR;
                            res_valid <= 1'b0;
                            mac_clr   <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        cnt   <= '0;
                        state <= RUN;
                    end
                    RUN: begin
                        if (fire) begin
                            cnt <= cnt + CW'(1);
                            if (cnt == CW'(COLS - 1)) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        state <= CAPTURE;
                    end
                    CAPTURE: begin
                        res       <= mac_c;
                        res_valid <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_matvec_ctrl.sv
// Scoreboard bench: behavioural FIFOs and MAC bank around matvec_ctrl, results checked on done.
module tb_matvec_ctrl;
    localparam int DW   = 8;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int AW   = 3 * DW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [ROWS-1:0]      a_empty;
    logic                 b_empty;
    logic [ROWS:0]        fifo_rd_en;
    logic                 mac_clr;
    logic [ROWS-1:0]      mac_en;
    logic [ROWS*AW-1:0]   mac_c;
    logic [ROWS*AW-1:0]   res;
    logic                 res_valid;
    logic                 busy;
    logic                 done;

    matvec_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_empty(a_empty), .b_empty(b_empty), .fifo_rd_en(fifo_rd_en),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_c(mac_c), .res(res),
        .res_valid(res_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIFOs with registered output, reloaded by the load pulse.
    logic [DW-1:0] a_mat [ROWS][COLS];
    logic [DW-1:0] b_vec [COLS];
    int            a_idx [ROWS];
    int            b_idx = 0;
    logic [DW-1:0] a_out [ROWS];
    logic [DW-1:0] b_out = '0;
    logic          load = 1'b0;
    logic [ROWS-1:0] a_force = '0;
    logic          b_force = 1'b0;

    initial for (int r = 0; r < ROWS; r++) begin a_idx[r] = 0; a_out[r] = '0; end

    always_comb begin
        a_empty = '0;
        for (int r = 0; r < ROWS; r++) a_empty[r] = (a_idx[r] >= COLS) || a_force[r];
        b_empty = (b_idx >= COLS) || b_force;
    end

    always @(posedge clk) begin
        if (load) begin
            for (int r = 0; r < ROWS; r++) a_idx[r] <= 0;
            b_idx <= 0;
        end else begin
            for (int r = 0; r < ROWS; r++)
                if (fifo_rd_en[r] && a_idx[r] < COLS) begin
                    a_out[r] <= a_mat[r][a_idx[r]];
                    a_idx[r] <= a_idx[r] + 1;
                end
            if (fifo_rd_en[ROWS] && b_idx < COLS) begin
                b_out <= b_vec[b_idx];
                b_idx <= b_idx + 1;
            end
        end
    end

    logic [AW-1:0] acc [ROWS];
    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (mac_clr) acc[r] <= '0;
            else if (mac_en[r]) acc[r] <= acc[r] + AW'(a_out[r]) * AW'(b_out);
        end
    end
    always_comb begin
        mac_c = '0;
        for (int r = 0; r < ROWS; r++) mac_c[r*AW +: AW] = acc[r];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [ROWS*AW-1:0] res;
        int                 cyc;
    } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (mac_clr || mac_en != '0) check("clr_en_exclusive", longint'(mac_clr && |mac_en), 0);
            if (mac_en != '0) check("mac_en_uniform", longint'(mac_en), longint'({ROWS{1'b1}}));
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("res_valid_on_done", longint'(res_valid), 1);
                    check("busy_on_done", longint'(busy), 0);
                    for (int r = 0; r < ROWS; r++)
                        check($sformatf("res_row%0d", r), longint'(res[r*AW +: AW]),
                              longint'(e.res[r*AW +: AW]));
                end
            end
        end
    end

    int t0 = 0;
    logic [ROWS*AW-1:0] exp_basic, exp_max;

    task automatic load_data(input bit maxval);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                a_mat[r][c] = maxval ? 8'd255 : DW'(r + 1);
                b_vec[c]    = maxval ? 8'd255 : DW'(c + 1);
            end
    endtask

    task automatic launch(input bit push, input logic [ROWS*AW-1:0] exp, input int lat);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        load  = 1'b1;
        t0    = cyc;
        if (push) begin
            e.res = exp;
            e.cyc = t0 + lat;
            q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        load  = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_res_valid"}, longint'(res_valid), 0);
        check({tag, "_mac_clr"}, longint'(mac_clr), 0);
        check({tag, "_mac_en"}, longint'(mac_en), 0);
        check({tag, "_rd_en"}, longint'(fifo_rd_en), 0);
        check({tag, "_res"}, longint'(|res), 0);
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++) begin
            exp_basic[r*AW +: AW] = AW'(36 * (r + 1));
            exp_max[r*AW +: AW]   = AW'(520200);
        end
        load_data(1'b0);

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Basic run, no stalls.
        launch(1'b1, exp_basic, 12);
        drain(40);

        // B empty for three RUN cycles.
        launch(1'b1, exp_basic, 15);
        repeat (4) @(posedge clk);
        #1;
        b_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b_stall_rd_en", longint'(fifo_rd_en), 0);
            @(posedge clk); #1;
        end
        b_force = 1'b0;
        drain(40);

        // One A row empty for a single cycle.
        launch(1'b1, exp_basic, 13);
        repeat (3) @(posedge clk);
        #1;
        a_force = 8'h20;
        @(negedge clk);
        check("a_stall_rd_en", longint'(fifo_rd_en), 0);
        @(posedge clk); #1;
        a_force = '0;
        drain(40);

        // Abort on the fourth fire.
        launch(1'b0, exp_basic, 0);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_rd_en", longint'(fifo_rd_en), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", longint'(busy), 0);
        check("abort_res_valid", longint'(res_valid), 0);
        for (int i = 0; i < 14; i++) begin
            check("abort_mac_en", longint'(mac_en), 0);
            @(negedge clk);
        end
        check("abort_res_valid_late", longint'(res_valid), 0);
        launch(1'b1, exp_basic, 12);
        drain(40);

        // Max operands, with a start pulse during RUN that must be ignored.
        load_data(1'b1);
        launch(1'b1, exp_max, 12);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain(40);
        repeat (15) @(posedge clk);
        #1;

        // Reset in the middle of RUN.
        load_data(1'b0);
        launch(1'b0, exp_basic, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", longint'(busy), 0);
        check("post_reset_rd_en", longint'(fifo_rd_en), 0);
        launch(1'b1, exp_basic, 12);
        drain(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
